// File: rtl/sound_out_filter.sv
// sound_out_filter
//
// Audio post-processing between the game core's 8-bit unsigned sound byte
// and the 16-bit platform audio output. The sound byte is decimated to one
// sample every CLKDIV master clocks, passed through a first-order IIR
// low-pass (alpha = 2^-SHIFT) and presented as a registered 16-bit sample
// together with a one-cycle strobe.
//
// Optional feature, macro SOUND_DCBLOCK_EN:
//   When defined, a DC-blocking stage subtracts a slow running mean from the
//   filtered sample, making SOUT signed and zero-centred. This adds one cycle
//   of latency and drives SSGN high.
//
// Parameters:
//   CLKDIV  MCLK cycles per output sample (1..65535)
//   SHIFT   low-pass coefficient exponent, alpha = 2^-SHIFT (1..8)
//
// Ports:
//   MCLK   in   1   master clock, all logic on its rising edge
//   RESET  in   1   synchronous active-high reset
//   SIN    in   8   unsigned sound byte from the game core
//   SOUT   out  16  filtered sample (unsigned, or two's complement with DC block)
//   SSGN   out  1   constant signedness flag for SOUT
//   SCE    out  1   one-cycle pulse on the cycle SOUT takes a new value

module sound_out_filter #(
    parameter int CLKDIV = 1000,
    parameter int SHIFT  = 3
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [7:0]  SIN,
    output logic [15:0] SOUT,
    output logic        SSGN,
    output logic        SCE
);

    localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);

    logic [15:0]        div;
    logic               tick;
    logic [15:0]        x;
    logic               x_valid;
    logic [15:0]        y;
    logic               y_valid;
    logic signed [16:0] diff;
    logic               out_valid;
    logic [15:0]        out_data;

    assign tick = (div == DIV_LAST);

    // Sample-rate divider; wraps after the tick cycle so the tick repeats
    // every CLKDIV cycles (every cycle when CLKDIV is 1).
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 16'd1;
        end
    end

    // Stage 0: capture the sound byte as a 16-bit value on the tick only.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            x       <= '0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= tick;
            if (tick) begin
                x <= {SIN, 8'h00};
            end
        end
    end

    // Stage 1: y += (x - y) >>> SHIFT. The arithmetic shift floors, so a
    // falling input lands on x exactly while a rising one stops just short.
    // y never leaves [0, 0xFF00], so the truncation back to 16 bits is exact.
    assign diff = signed'({1'b0, x}) - signed'({1'b0, y});

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                y <= y + 16'(diff >>> SHIFT);
            end
        end
    end

`ifdef SOUND_DCBLOCK_EN

    logic [23:0]        m;
    logic signed [24:0] m_err;
    logic signed [16:0] e_raw;
    logic [15:0]        e_sat;
    logic [15:0]        dc;
    logic               dc_valid;

    // m tracks the mean of y with 8 fraction bits and a 2^-10 coefficient.
    // The output uses the mean from before this update.
    assign m_err = signed'({1'b0, y, 8'h00}) - signed'({1'b0, m});
    assign e_raw = signed'({1'b0, y}) - signed'({1'b0, m[23:8]});

    // Clamp the 17-bit difference into the signed 16-bit output range.
    always_comb begin
        e_sat = e_raw[15:0];
        if (e_raw > 17'sd32767) begin
            e_sat = 16'h7FFF;
        end else if (e_raw < -17'sd32768) begin
            e_sat = 16'h8000;
        end
    end

    // DC-blocking stage, running on the cycle after each y update.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            m        <= '0;
            dc       <= '0;
            dc_valid <= 1'b0;
        end else begin
            dc_valid <= y_valid;
            if (y_valid) begin
                m  <= m + 24'(m_err >>> 10);
                dc <= e_sat;
            end
        end
    end

    assign out_valid = dc_valid;
    assign out_data  = dc;
    assign SSGN      = 1'b1;

`else

    assign out_valid = y_valid;
    assign out_data  = y;
    assign SSGN      = 1'b0;

`endif

    // Output register: SOUT holds between strobes, SCE pulses once per sample.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            SOUT <= '0;
            SCE  <= 1'b0;
        end else begin
            SCE <= out_valid;
            if (out_valid) begin
                SOUT <= out_data;
            end
        end
    end

endmodule

// File: tb/tb_sound_out_filter.sv
// tb_sound_out_filter
//
// Self-checking bench for sound_out_filter. The main instance runs with
// CLKDIV=4, SHIFT=3; a second instance with CLKDIV=1 exercises back-to-back
// samples. Expected samples come from a sample-level reference filter written
// with plain integer arithmetic and a queue of pending outputs.
// Honours SOUND_DCBLOCK_EN the same way as the design.

module tb_sound_out_filter;

    localparam int CLKDIV = 4;
    localparam int SHIFT  = 3;
    localparam int SHIFT1 = 2;

`ifdef SOUND_DCBLOCK_EN
    localparam int   PIPE       = 3;
    localparam logic SIGNED_OUT = 1'b1;
`else
    localparam int   PIPE       = 2;
    localparam logic SIGNED_OUT = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [15:0] value;
    } pend_t;

    logic        mclk = 1'b0;
    logic        reset;
    logic [7:0]  sin;
    logic [7:0]  sin1;
    logic [15:0] sout;
    logic [15:0] sout1;
    logic        ssgn;
    logic        ssgn1;
    logic        sce;
    logic        sce1;

    int          errors = 0;
    int          checks = 0;

    int          edge_n;
    longint      ref_y;
    longint      ref_m;
    logic [15:0] exp_sout;
    logic        exp_sce;
    pend_t       pend[$];

    always #5 mclk = ~mclk;

    sound_out_filter #(.CLKDIV(CLKDIV), .SHIFT(SHIFT)) dut (
        .MCLK  (mclk),
        .RESET (reset),
        .SIN   (sin),
        .SOUT  (sout),
        .SSGN  (ssgn),
        .SCE   (sce)
    );

    sound_out_filter #(.CLKDIV(1), .SHIFT(SHIFT1)) dut1 (
        .MCLK  (mclk),
        .RESET (reset),
        .SIN   (sin1),
        .SOUT  (sout1),
        .SSGN  (ssgn1),
        .SCE   (sce1)
    );

    function automatic longint floordiv(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // One filtered sample: low-pass update, then the optional DC removal.
    task automatic ref_sample(input int shift, input int s, inout longint y,
                              inout longint m, output logic [15:0] out);
        longint e;
        y = y + floordiv(longint'(s) * 256 - y, longint'(1) << shift);
        e = y - floordiv(m, 256);
        m = m + floordiv(y * 256 - m, 1024);
        if (e > 32767) e = 32767;
        if (e < -32768) e = -32768;
`ifdef SOUND_DCBLOCK_EN
        out = 16'(e);
`else
        out = 16'(y);
`endif
    endtask

    // Drives one cycle, advances the reference across the rising edge and
    // returns at the following falling edge, where outputs are compared.
    task automatic advance(input logic [7:0] s, input logic r);
        logic [15:0] v;
        sin   = s;
        reset = r;
        @(posedge mclk);
        if (r) begin
            edge_n   = 0;
            ref_y    = 0;
            ref_m    = 0;
            exp_sout = '0;
            exp_sce  = 1'b0;
            pend.delete();
        end else begin
            edge_n++;
            exp_sce = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                exp_sout = pend[0].value;
                exp_sce  = 1'b1;
                void'(pend.pop_front());
            end
            if (edge_n % CLKDIV == 0) begin
                ref_sample(SHIFT, int'(s), ref_y, ref_m, v);
                pend.push_back('{due: edge_n + PIPE, value: v});
            end
        end
        @(negedge mclk);
    endtask

    task automatic test_reset();
        int first;
        first = -1;
        checks++;
        if (ssgn !== SIGNED_OUT) begin
            errors++;
            $display("[TB] FAIL ssgn_static: got %b expected %b", ssgn, SIGNED_OUT);
        end
        for (int i = 0; i < 3; i++) begin
            advance(8'hFF, 1'b1);
            checks++;
            if (sout !== 16'h0000 || sce !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_state: got sout=%h sce=%b expected 0000/0", sout, sce);
            end
        end
        for (int k = 1; k <= CLKDIV + 8; k++) begin
            advance(8'hFF, 1'b0);
            checks++;
            if (sce !== exp_sce || sout !== exp_sout) begin
                errors++;
                $display("[TB] FAIL reset_release: got %h/%b expected %h/%b", sout, sce, exp_sout, exp_sce);
            end
            if (sce === 1'b1 && first < 0) begin
                first = k;
                checks++;
                if (sout !== 16'h1FE0) begin
                    errors++;
                    $display("[TB] FAIL first_sample: got %h expected 1fe0", sout);
                end
            end
        end
        // Edge CLKDIV+2 after the reset edge opens the (CLKDIV+3)-th cycle.
        checks++;
        if (first != CLKDIV + 2) begin
            errors++;
            $display("[TB] FAIL first_sce_latency: got edge %0d expected %0d", first, CLKDIV + 2);
        end
    endtask

    task automatic test_cadence();
        int   pulses;
        logic prev;
        pulses = 0;
        prev   = sce;
        for (int k = 0; k < 40; k++) begin
            advance(8'($urandom_range(0, 255)), 1'b0);
            checks++;
            if (sce !== exp_sce || sout !== exp_sout) begin
                errors++;
                $display("[TB] FAIL cadence_sample: got %h/%b expected %h/%b", sout, sce, exp_sout, exp_sce);
            end
            checks++;
            if (prev === 1'b1 && sce === 1'b1) begin
                errors++;
                $display("[TB] FAIL cadence_single: got consecutive sce at step %0d expected single pulse", k);
            end
            if (sce === 1'b1) pulses++;
            prev = sce;
        end
        checks++;
        if (pulses < 9 || pulses > 11) begin
            errors++;
            $display("[TB] FAIL cadence_count: got %0d pulses expected 10", pulses);
        end
    endtask

    task automatic test_step_up();
        logic [15:0] prev;
        advance(8'h00, 1'b1);
        for (int k = 0; k < 3 * CLKDIV; k++) advance(8'h00, 1'b0);
        prev = sout;
        for (int k = 0; k < 150 * CLKDIV; k++) begin
            advance(8'hFF, 1'b0);
            checks++;
            if (sce !== exp_sce || sout !== exp_sout) begin
                errors++;
                $display("[TB] FAIL step_up_sample: got %h/%b expected %h/%b", sout, sce, exp_sout, exp_sce);
            end
`ifndef SOUND_DCBLOCK_EN
            if (sce === 1'b1) begin
                checks++;
                if (sout < prev) begin
                    errors++;
                    $display("[TB] FAIL step_up_monotonic: got %h after %h expected non-decreasing", sout, prev);
                end
                prev = sout;
            end
`endif
        end
`ifndef SOUND_DCBLOCK_EN
        checks++;
        if (sout < 16'hFEF9 || sout > 16'hFF00) begin
            errors++;
            $display("[TB] FAIL step_up_settle: got %h expected fef9..ff00", sout);
        end
`endif
    endtask

    task automatic test_step_down();
        logic [15:0] prev;
        prev = sout;
        for (int k = 0; k < 150 * CLKDIV; k++) begin
            advance(8'h00, 1'b0);
            checks++;
            if (sce !== exp_sce || sout !== exp_sout) begin
                errors++;
                $display("[TB] FAIL step_down_sample: got %h/%b expected %h/%b", sout, sce, exp_sout, exp_sce);
            end
`ifndef SOUND_DCBLOCK_EN
            if (sce === 1'b1) begin
                checks++;
                if (sout > prev) begin
                    errors++;
                    $display("[TB] FAIL step_down_monotonic: got %h after %h expected non-increasing", sout, prev);
                end
                prev = sout;
            end
`endif
        end
`ifndef SOUND_DCBLOCK_EN
        checks++;
        if (sout !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL step_down_final: got %h expected 0000", sout);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int first;
        first = -1;
        advance(8'hFF, 1'b1);
        for (int k = 0; k < CLKDIV; k++) advance(8'hFF, 1'b0);
        // A sample is now held in the first pipeline stage; drop it.
        advance(8'hFF, 1'b1);
        for (int k = 1; k <= CLKDIV + 4; k++) begin
            advance(8'hFF, 1'b0);
            checks++;
            if (sce !== exp_sce || sout !== exp_sout) begin
                errors++;
                $display("[TB] FAIL mid_reset_sample: got %h/%b expected %h/%b", sout, sce, exp_sout, exp_sce);
            end
            if (sce === 1'b1 && first < 0) begin
                first = k;
                checks++;
                if (sout !== 16'h1FE0) begin
                    errors++;
                    $display("[TB] FAIL mid_reset_value: got %h expected 1fe0", sout);
                end
            end
        end
        checks++;
        if (first != CLKDIV + 2) begin
            errors++;
            $display("[TB] FAIL mid_reset_discard: got first sce at edge %0d expected %0d", first, CLKDIV + 2);
        end
    endtask

    task automatic test_random();
        logic [7:0] s;
        advance(8'h00, 1'b1);
        s = 8'h00;
        for (int k = 0; k < 40 * CLKDIV; k++) begin
            if (k % CLKDIV == 0) s = 8'($urandom_range(0, 255));
            advance(s, 1'b0);
            checks++;
            if (sce !== exp_sce || sout !== exp_sout) begin
                errors++;
                $display("[TB] FAIL random_sample: got %h/%b expected %h/%b", sout, sce, exp_sout, exp_sce);
            end
        end
    endtask

    task automatic test_back_to_back();
        longint      y1;
        longint      m1;
        logic [15:0] outs[$];
        logic [15:0] v;
        logic [15:0] want;
        y1   = 0;
        m1   = 0;
        sin1 = 8'h00;
        advance(8'h00, 1'b1);
        checks++;
        if (ssgn1 !== SIGNED_OUT) begin
            errors++;
            $display("[TB] FAIL b2b_ssgn: got %b expected %b", ssgn1, SIGNED_OUT);
        end
        for (int n = 1; n <= 40; n++) begin
            sin1 = 8'($urandom_range(0, 255));
            ref_sample(SHIFT1, int'(sin1), y1, m1, v);
            outs.push_back(v);
            advance(8'($urandom_range(0, 255)), 1'b0);
            checks++;
            if (sce1 !== 1'(n > PIPE)) begin
                errors++;
                $display("[TB] FAIL b2b_sce: got %b expected %b at edge %0d", sce1, n > PIPE, n);
            end
            if (n > PIPE) begin
                want = outs[n - PIPE - 1];
                checks++;
                if (sout1 !== want) begin
                    errors++;
                    $display("[TB] FAIL b2b_sout: got %h expected %h at edge %0d", sout1, want, n);
                end
            end
        end
    endtask

`ifdef SOUND_DCBLOCK_EN
    task automatic test_dc_block();
        int settled;
        int peak;
        int mag;
        advance(8'h80, 1'b1);
        for (int phase = 0; phase < 2; phase++) begin
            settled = 0;
            peak    = 0;
            for (int k = 0; k < 7000 * CLKDIV && settled == 0; k++) begin
                advance(phase == 0 ? 8'h80 : 8'hFF, 1'b0);
                checks++;
                if (sce !== exp_sce || sout !== exp_sout) begin
                    errors++;
                    $display("[TB] FAIL dc_sample: got %h/%b expected %h/%b", sout, sce, exp_sout, exp_sce);
                end
                mag = int'($signed(sout));
                if (mag > peak) peak = mag;
                if (mag < 0) mag = -mag;
                if (k > 200 * CLKDIV && mag < 'h100) settled = 1;
            end
            checks++;
            if (settled == 0) begin
                errors++;
                $display("[TB] FAIL dc_decay: got sout=%h expected |sout| < 0100 in phase %0d", sout, phase);
            end
            checks++;
            if (peak < 'h1000) begin
                errors++;
                $display("[TB] FAIL dc_excursion: got peak %h expected >= 1000 in phase %0d", peak, phase);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        sin   = 8'h00;
        sin1  = 8'h00;
        @(negedge mclk);
        $display("[TB] start CLKDIV=%0d SHIFT=%0d", CLKDIV, SHIFT);
        test_reset();
        test_cadence();
        test_step_up();
        test_step_down();
        test_mid_reset();
        test_random();
        test_back_to_back();
`ifdef SOUND_DCBLOCK_EN
        test_dc_block();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
